// File: rtl/sync_ram_256x10_pkg.sv
// Shared widths and word/address types for the 256x10 scratch RAM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sync_ram_256x10_pkg;

    // Default geometry: 256 words of 10 bits.
    localparam int DATA_W_DFLT = 10;
    localparam int ADDR_W_DFLT = 8;
    localparam int DEPTH_DFLT  = 2 ** ADDR_W_DFLT;

    typedef logic [DATA_W_DFLT-1:0] word_t;
    typedef logic [ADDR_W_DFLT-1:0] addr_t;

endpackage : sync_ram_256x10_pkg

// File: rtl/sync_ram_256x10_if.sv
// Port bundle for the single-port RAM: enable, write enable, address, write and read data.
// Latency: Dout is registered, valid one clock after the addressing edge.
// Backpressure: none; the RAM accepts an access on every enabled edge.
interface sync_ram_256x10_if
    import sync_ram_256x10_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int ADDR_W = ADDR_W_DFLT
);

    logic              EN;
    logic              WE;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] Din;
    logic [DATA_W-1:0] Dout;

    // Requester side: issues accesses and consumes read data.
    modport master (
        output EN,
        output WE,
        output ADDR,
        output Din,
        input  Dout
    );

    // Memory side: accepts accesses and returns registered read data.
    modport slave (
        input  EN,
        input  WE,
        input  ADDR,
        input  Din,
        output Dout
    );

endinterface : sync_ram_256x10_if

// File: rtl/sync_ram_256x10.sv
// Single-port 256x10 synchronous RAM, write-first, with a registered read port.
// Latency: 1 clock from addressing edge to Dout; writes show Din on Dout the same edge.
// Backpressure: none; EN=0 idles the port and Dout holds.
module sync_ram_256x10
    import sync_ram_256x10_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int ADDR_W = ADDR_W_DFLT
) (
    input  logic                CLK,
    input  logic                RST,
    sync_ram_256x10_if.slave    bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Storage starts at zero so unwritten words never read back as X;
    // contents deliberately survive reset.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic do_write;
    logic do_read;

    // Decode the access type once; reset blocks every write.
    always_comb begin
        do_write = 1'b0;
        do_read  = 1'b0;
        if (RST && bus.EN) begin
            do_write = bus.WE;
            do_read  = !bus.WE;
        end
    end

    // Array write port, kept free of reset so it maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (do_write) begin
            mem[bus.ADDR] <= bus.Din;
        end
    end

    // Output register: async clear, write-first forwarding, hold when idle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.Dout <= '0;
        end else if (do_write) begin
            bus.Dout <= bus.Din;
        end else if (do_read) begin
            bus.Dout <= mem[bus.ADDR];
        end
    end

endmodule : sync_ram_256x10

// File: tb/tb_sync_ram_256x10.sv
// Self-checking bench for sync_ram_256x10: directed steps then a random soak against an array model.
// Latency: checks Dout 1 time unit after each rising edge and mid-cycle around reset.
// Backpressure: n/a.
module tb_sync_ram_256x10;
    import sync_ram_256x10_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    // Reference model: a sparse word store plus the expected read register.
    word_t model_mem [int];
    word_t model_dout = '0;

    sync_ram_256x10_if bus ();

    sync_ram_256x10 dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop if the run ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic word_t model_read(int a);
        return model_mem.exists(a) ? model_mem[a] : word_t'(0);
    endfunction

    task automatic check(input string tag, input word_t obs, input word_t exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one access at the falling edge, clock it, update the model, settle.
    task automatic drive_edge(input logic en, input logic we, input int a, input int d);
        @(negedge clk);
        bus.EN   = en;
        bus.WE   = we;
        bus.ADDR = addr_t'(a);
        bus.Din  = word_t'(d);
        @(posedge clk);
        if (rst && en) begin
            if (we) begin
                model_mem[a] = word_t'(d);
                model_dout   = word_t'(d);
            end else begin
                model_dout = model_read(a);
            end
        end
        #1;
    endtask

    initial begin
        bus.EN   = 1'b0;
        bus.WE   = 1'b0;
        bus.ADDR = '0;
        bus.Din  = '0;

        // Power-up reset.
        #2;
        check("reset_init", bus.Dout, 10'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;

        // Write/readback with write-first forwarding.
        drive_edge(1'b1, 1'b1, 0, 29);
        check("wr0_wf", bus.Dout, 10'd29);
        drive_edge(1'b1, 1'b1, 1, 45);
        check("wr1_wf", bus.Dout, 10'd45);
        drive_edge(1'b1, 1'b0, 1, 0);
        check("rd1", bus.Dout, 10'd45);
        drive_edge(1'b1, 1'b0, 0, 0);
        check("rd0", bus.Dout, 10'd29);

        // Async reset mid-cycle clears Dout but not the array, and blocks writes.
        drive_edge(1'b1, 1'b0, 1, 0);
        check("pre_rst_rd1", bus.Dout, 10'd45);
        #2 rst = 1'b0;
        #1;
        check("rst_async", bus.Dout, 10'd0);
        drive_edge(1'b1, 1'b1, 1, 99);
        check("rst_hold", bus.Dout, 10'd0);
        #2 rst = 1'b1;
        drive_edge(1'b1, 1'b0, 1, 0);
        check("rst_preserve", bus.Dout, 10'd45);

        // Overwrite replaces the whole word.
        drive_edge(1'b1, 1'b1, 2, 13);
        drive_edge(1'b1, 1'b1, 3, 565);
        check("wr3_wf", bus.Dout, 10'd565);
        drive_edge(1'b1, 1'b1, 3, 0);
        drive_edge(1'b1, 1'b0, 3, 0);
        check("ovw_rd3", bus.Dout, 10'd0);
        drive_edge(1'b1, 1'b0, 2, 0);
        check("ovw_rd2", bus.Dout, 10'd13);

        // Enable gating: WE without EN must neither write nor move Dout.
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b0, 1'b1, 2, 777);
            check("en_hold", bus.Dout, 10'd13);
        end
        drive_edge(1'b1, 1'b0, 2, 0);
        check("en_rd2", bus.Dout, 10'd13);

        // Boundary addresses and an unwritten location.
        drive_edge(1'b1, 1'b1, 255, 1023);
        drive_edge(1'b1, 1'b1, 0, 1);
        drive_edge(1'b1, 1'b0, 255, 0);
        check("bnd_rd255", bus.Dout, 10'd1023);
        drive_edge(1'b1, 1'b0, 0, 0);
        check("bnd_rd0", bus.Dout, 10'd1);
        drive_edge(1'b1, 1'b0, 128, 0);
        check("unwritten_128", bus.Dout, 10'd0);

        // Random soak with occasional asynchronous reset pulses.
        for (int n = 0; n < 2000; n++) begin
            int a;
            a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15))
                                            : int'($urandom_range(0, 255));
            drive_edge(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                       a, int'($urandom_range(0, 1023)));
            check("soak", bus.Dout, model_dout);
            if ($urandom_range(0, 49) == 0) begin
                #2 rst = 1'b0;
                model_dout = '0;
                #1;
                check("soak_rst_async", bus.Dout, 10'd0);
                drive_edge(1'b1, 1'($urandom_range(0, 1)),
                           int'($urandom_range(0, 255)), int'($urandom_range(0, 1023)));
                check("soak_rst_hold", bus.Dout, 10'd0);
                #2 rst = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sync_ram_256x10

// File: doc/sync_ram_256x10.md
Name: sync_ram_256x10

Overview:
- Single-port synchronous RAM: 256 words x 10 bits, one clock domain.
- One shared address bus for write and read. The read port is registered.
- Serves as a generic scratch or storage memory inside lab datapaths.
- Written so synthesis tools infer block RAM with an output register.

Parameters:
- DATA_W, 10, word width in bits (Din, Dout, array entries).
- ADDR_W, 8, address width in bits.
- DEPTH, 2**ADDR_W (256), number of words. Derived; do not override independently.

Ports:
- CLK  input  1  clock; all state changes on the rising edge except reset.
- RST  input  1  reset, asynchronous, active-low (RST=0 asserts reset).
- EN  input  1  port enable; when 0, no read and no write.
- WE  input  1  write enable; qualified by EN.
- ADDR  input  ADDR_W  word address for both read and write.
- Din  input  DATA_W  write data.
- Dout  output  DATA_W  registered read data.

Behaviour:
- Storage is an array of DEPTH words x DATA_W bits.
- Simulation initial contents: all zeros.
- Reset asserted (RST=0):
  - Dout goes to 0 immediately, without waiting for a clock edge.
  - Dout stays 0 while RST=0.
  - Writes are blocked while RST=0.
  - Memory contents are NOT cleared; they are preserved through reset.
- Reset release is synchronous-safe: the first clock edge with RST=1 performs normal operation.
- Rising CLK edge, RST=1, EN=1, WE=1 (write, write-first):
  - mem[ADDR] <= Din.
  - Dout <= Din in the same edge (new data appears on the read port).
- Rising CLK edge, RST=1, EN=1, WE=0 (read):
  - Dout <= mem[ADDR].
  - Read latency is 1 cycle: ADDR is sampled at edge N, data is valid after edge N.
- Rising CLK edge, RST=1, EN=0 (idle):
  - Memory is unchanged and Dout holds its previous value.
  - WE is ignored.
- Addresses:
  - All 2**ADDR_W addresses are valid; there is no out-of-range case and no wrap logic.
- Write then read of the same address on back-to-back cycles:
  - The read returns the newly written value; no stale-data hazard.
- Overwrite:
  - A later write to the same address fully replaces the word; no masking or partial writes.
- Inputs are assumed stable around the rising edge; there is no input registering beyond the array and Dout.
- No X propagation from the array: unwritten locations read as 0 in simulation.

Decomposition:
- Shared package holds:
  - the default DATA_W and ADDR_W constants;
  - a word typedef (logic [DATA_W-1:0]);
  - an address typedef (logic [ADDR_W-1:0]).
- No sub-module. The array and the output register live in one always block for write and one for Dout, to keep BRAM inference clean.
- A behavioural reference model (associative array) belongs in the bench, not the RTL.

Test Plan:
1. Reset: drive RST=0 mid-cycle with Dout=45 -> Dout=0 immediately, before the next edge. Release RST=1, then read addr 1 -> Dout=45 after 1 edge (contents preserved).
2. Write/readback: write 29@0, then 45@1 (EN=1, WE=1) -> Dout shows 29, then 45 (write-first). Read addr 1 -> 45; read addr 0 -> 29.
3. Overwrite: write 13@2, 565@3, then 0@3; read addr 3 -> 0; read addr 2 -> 13.
4. Enable gating: EN=0, WE=1, Din=777, ADDR=2 for 3 edges -> Dout holds its last value; a subsequent read of addr 2 -> 13.
5. Boundary addresses: write 1023@255 and 1@0; read 255 -> 1023; read 0 -> 1. Unwritten addr 128 reads 0.
6. Random soak: 2000 random EN/WE/ADDR/Din cycles checked against the bench model each edge, with random async RST pulses -> zero mismatches; Dout=0 during every reset pulse.
